decoder_scan: RTL and testbench
===============================

// Module: decoder_scan
// PURPOSE
//  Parametrised, registered SEL_W-to-2**SEL_W one-hot decoder with two modes.
//  - Direct mode: latches a select value on a load strobe.
//  - Scan mode: walks the active output through every line, holding each one
//    for a programmable dwell time.
//  Drives row/digit/chip-select lines in multiplexed display and bus-select
//  paths; the successor to the fixed 2-to-4 combinational decoder.
// PARAMETERS
//  SEL_W      2  select width; output width N = 2**SEL_W
//  DWELL_W    8  width of dwell-count input
//  ACTIVE_LOW 0  1: active output line is 0, inactive lines are 1
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        asynchronous active-low reset
//  en       in   1        block enable; 0 forces all outputs inactive
//  mode     in   1        0 = direct, 1 = scan
//  load     in   1        strobe: capture sel_in (both modes)
//  sel_in   in   SEL_W    select value captured on load
//  dwell    in   DWELL_W  extra cycles per line in scan (hold = dwell+1 cycles)
//  dec_out  out  N        registered one-hot decode of cur_sel (polarity per ACTIVE_LOW)
//  cur_sel  out  SEL_W    registered current select index
//  wrap     out  1        1-cycle pulse when scan advances cur_sel from N-1 to 0
//  busy     out  1        1 while in SCAN state
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; cur_sel=0; dwell_cnt=0; wrap=0; busy=0;
//   dec_out all inactive ('0 or '1 per ACTIVE_LOW).
//  States:
//   - IDLE: en=0; outputs inactive. en=1 -> DIRECT if mode=0, SCAN if mode=1.
//   - DIRECT: dec_out = onehot(cur_sel); cur_sel changes only on load.
//   - SCAN: cur_sel auto-advances.
//  en=0 in any state -> IDLE next cycle; dec_out inactive next cycle;
//   cur_sel held; dwell_cnt cleared.
//  Latency: every dec_out change appears 1 cycle after its cause
//   (load, advance, en/mode edge). No combinational input->output path.
//  Direct load: cur_sel <= sel_in; dec_out = onehot(sel_in) on the next cycle.
//  Scan advance:
//   - dwell_cnt increments each cycle.
//   - When dwell_cnt == dwell: dwell_cnt <= 0; cur_sel <= cur_sel+1 (mod N).
//   - wrap=1 for that cycle iff old cur_sel == N-1.
//   - dwell=0: advance every cycle.
//   - dwell changed mid-count: compared live. If dwell_cnt > new dwell, count
//     runs to all-ones and wraps (no early advance).
//  Load in scan mode: has priority over advance.
//   - cur_sel <= sel_in; dwell_cnt <= 0; no wrap pulse.
//   - Scan continues from sel_in.
//  Mode switches:
//   - SCAN->DIRECT (mode 1->0): cur_sel frozen at current value; dwell_cnt
//     cleared; wrap=0.
//   - DIRECT->SCAN: scan starts at current cur_sel with dwell_cnt=0.
//  Simultaneous en falling edge + load: en wins; load ignored.
//  Exactly one dec_out line is active whenever state != IDLE. busy == (state==SCAN).
// STRUCTURE
//  Shared package decoder_pkg:
//   - state enum {IDLE, DIRECT, SCAN}
//   - function onehot(sel) returning N-bit vector
//  Sub-module dwell_counter (DWELL_W):
//   - inputs: clear, enable, dwell
//   - output: tick when count == dwell
//  The rest (FSM, cur_sel register, output register) stays in decoder_scan.
// TESTING
//  T1 reset:
//   - rst_n=0 mid-scan -> dec_out=0000, cur_sel=0, wrap=0, busy=0 immediately.
//  T2 direct, SEL_W=2:
//   - en=1, mode=0, load with sel_in=0..3 -> dec_out 0001, 0010, 0100, 1000,
//     each 1 cycle after its load.
//  T3 scan, dwell=2:
//   - each line held 3 cycles; sequence 0001->0010->0100->1000->0001.
//   - wrap high exactly on the 1000->0001 cycle.
//  T4 scan, dwell=0:
//   - dec_out changes every cycle; wrap every 4th cycle.
//   - load sel_in=2 mid-scan -> next cycle dec_out=0100, count restarts, no wrap.
//  T5 mode/enable:
//   - mode 1->0 at cur_sel=1 -> dec_out stays 0010.
//   - en=0 -> dec_out=0000 next cycle.
//   - en=1 -> 0010 restored.
//  T6 ACTIVE_LOW=1, SEL_W=3:
//   - direct load 5 -> dec_out=8'b11011111; reset -> 8'hFF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
// Select widths up to MAX_SEL_W are supported by the onehot helper.
package decoder_pkg;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_N     = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control/status bundle between a controller (master) and decoder_scan (slave).
// load is a single-cycle strobe with no ready: it is taken on any clock edge where en=1.
interface decoder_scan_if
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
);
    localparam int N = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic               load;
    logic [SEL_W-1:0]   sel_in;
    logic [DWELL_W-1:0] dwell;
    logic [N-1:0]       dec_out;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;
    logic               busy;
    state_t             fsm_state;

    modport master (
        output en, mode, load, sel_in, dwell,
        input  dec_out, cur_sel, wrap, busy, fsm_state
    );

    modport slave (
        input  en, mode, load, sel_in, dwell,
        output dec_out, cur_sel, wrap, busy, fsm_state
    );

endinterface

// File: rtl/decoder_scan_dwell_counter.sv
// Per-line dwell counter: tick is high while count equals the live dwell value.
// A count already past a newly lowered dwell runs on through all-ones and wraps.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);
    logic [DWELL_W-1:0] count;

    assign tick = (count == dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + DWELL_W'(1);
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with direct-load and auto-scan modes.
// All outputs are registered from next-state values, so every change lands one cycle after its cause.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int DWELL_W    = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_scan_if.slave bus
);
    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] cur_sel;
    logic [SEL_W-1:0] next_sel;
    logic [N-1:0]     onehot_sel;
    logic [N-1:0]     dec_next;
    logic [N-1:0]     dec_q;
    logic             wrap_q;
    logic             busy_q;
    logic             scanning;
    logic             tick;
    logic             advance;
    logic             cnt_clear;

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (scanning),
        .dwell  (bus.dwell),
        .tick   (tick)
    );

    always_comb begin
        // Counting only happens once the FSM already sits in SCAN and still wants to scan.
        scanning  = (state == SCAN) && bus.en && bus.mode;
        advance   = scanning && tick && !bus.load;
        cnt_clear = !scanning || bus.load;

        if (!bus.en) begin
            next_state = IDLE;
        end else if (bus.mode) begin
            next_state = SCAN;
        end else begin
            next_state = DIRECT;
        end

        next_sel = cur_sel;
        if (bus.en && bus.load) begin
            next_sel = bus.sel_in;
        end else if (advance) begin
            next_sel = cur_sel + SEL_W'(1);
        end

        onehot_sel = N'(onehot(MAX_SEL_W'(next_sel)));
        if (next_state == IDLE) begin
            dec_next = INACTIVE;
        end else if (ACTIVE_LOW != 0) begin
            dec_next = ~onehot_sel;
        end else begin
            dec_next = onehot_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_sel <= '0;
            dec_q   <= INACTIVE;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= next_state;
            cur_sel <= next_sel;
            dec_q   <= dec_next;
            wrap_q  <= advance && (&cur_sel);
            busy_q  <= (next_state == SCAN);
        end
    end

    assign bus.dec_out   = dec_q;
    assign bus.cur_sel   = cur_sel;
    assign bus.wrap      = wrap_q;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: an active-high 2-bit instance and an active-low 3-bit instance.
module tb_decoder_scan;
    import decoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(2), .DWELL_W(8)) bus_a ();
    decoder_scan_if #(.SEL_W(3), .DWELL_W(8)) bus_b ();

    decoder_scan #(.SEL_W(2), .DWELL_W(8), .ACTIVE_LOW(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    decoder_scan #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    // {dec_out, cur_sel, wrap, busy}
    logic [7:0]  exp_q[$];
    logic [12:0] exp_b_q[$];

    typedef struct packed {
        logic       en;
        logic       mode;
        logic       load;
        logic [1:0] sel;
        logic [3:0] dec;
        logic [1:0] cs;
        logic       wrap;
        logic       busy;
    } vec_t;

    vec_t tbl[9];

    task automatic check_a(input string name);
        logic [7:0] got;
        logic [7:0] want;
        got = {bus_a.dec_out, bus_a.cur_sel, bus_a.wrap, bus_a.busy};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected entry queued, got %b", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got dec=%b sel=%0d wrap=%b busy=%b, want dec=%b sel=%0d wrap=%b busy=%b",
                         name, got[7:4], got[3:2], got[1], got[0],
                         want[7:4], want[3:2], want[1], want[0]);
            end
        end
    endtask

    task automatic check_b(input string name);
        logic [12:0] got;
        logic [12:0] want;
        got = {bus_b.dec_out, bus_b.cur_sel, bus_b.wrap, bus_b.busy};
        total++;
        if (exp_b_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expected entry queued, got %b", name, got);
        end else begin
            want = exp_b_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got dec=%b sel=%0d wrap=%b busy=%b, want dec=%b sel=%0d wrap=%b busy=%b",
                         name, got[12:5], got[4:2], got[1], got[0],
                         want[12:5], want[4:2], want[1], want[0]);
            end
        end
    endtask

    task automatic step_a(input logic en, input logic mode, input logic load,
                          input logic [1:0] sel, input logic [7:0] dwell,
                          input logic [3:0] dec, input logic [1:0] cs,
                          input logic wrap, input logic busy, input string name);
        bus_a.en     = en;
        bus_a.mode   = mode;
        bus_a.load   = load;
        bus_a.sel_in = sel;
        bus_a.dwell  = dwell;
        exp_q.push_back({dec, cs, wrap, busy});
        @(posedge clk);
        #1;
        check_a(name);
    endtask

    task automatic step_b(input logic en, input logic mode, input logic load,
                          input logic [2:0] sel, input logic [7:0] dwell,
                          input logic [7:0] dec, input logic [2:0] cs,
                          input logic wrap, input logic busy, input string name);
        bus_b.en     = en;
        bus_b.mode   = mode;
        bus_b.load   = load;
        bus_b.sel_in = sel;
        bus_b.dwell  = dwell;
        exp_b_q.push_back({dec, cs, wrap, busy});
        @(posedge clk);
        #1;
        check_b(name);
    endtask

    initial begin
        logic [1:0] s;
        logic [3:0] d;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b1000, 2'd3, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 2'd3, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 2'd2, 4'b1000, 2'd3, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0, 1'b0};

        // clock/reset
        rst_n        = 1'b0;
        bus_a.en     = 1'b0;
        bus_a.mode   = 1'b0;
        bus_a.load   = 1'b0;
        bus_a.sel_in = '0;
        bus_a.dwell  = '0;
        bus_b.en     = 1'b0;
        bus_b.mode   = 1'b0;
        bus_b.load   = 1'b0;
        bus_b.sel_in = '0;
        bus_b.dwell  = '0;
        #12;
        exp_q.push_back({4'b0000, 2'd0, 1'b0, 1'b0});
        check_a("reset_a");
        exp_b_q.push_back({8'hFF, 3'd0, 1'b0, 1'b0});
        check_b("reset_b");
        total++;
        if (bus_a.fsm_state !== IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d want %0d", bus_a.fsm_state, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // direct loads, hold, en falling edge with load
        for (int i = 0; i < 9; i++) begin
            step_a(tbl[i].en, tbl[i].mode, tbl[i].load, tbl[i].sel, 8'd0,
                   tbl[i].dec, tbl[i].cs, tbl[i].wrap, tbl[i].busy,
                   $sformatf("t2_direct[%0d]", i));
        end

        // scan with dwell=2: each line held 3 cycles, wrap on 3->0
        for (int k = 0; k < 14; k++) begin
            s = 2'((k / 3) % 4);
            d = 4'b0001 << s;
            step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd2, d, s, (k == 12), 1'b1,
                   $sformatf("t3_scan_dwell2[%0d]", k));
        end

        // scan with dwell=0 from line 0
        step_a(1'b1, 1'b0, 1'b1, 2'd0, 8'd0, 4'b0001, 2'd0, 1'b0, 1'b0, "t4_direct_zero");
        for (int k = 0; k < 8; k++) begin
            s = 2'(k % 4);
            d = 4'b0001 << s;
            step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, d, s, (k == 4), 1'b1,
                   $sformatf("t4_scan_dwell0[%0d]", k));
        end
        // load at line 3 beats the advance that would have wrapped
        step_a(1'b1, 1'b1, 1'b1, 2'd2, 8'd0, 4'b0100, 2'd2, 1'b0, 1'b1, "t4_load_mid_scan");
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b1000, 2'd3, 1'b0, 1'b1, "t4_after_load0");
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0001, 2'd0, 1'b1, 1'b1, "t4_after_load1");
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 4'b0010, 2'd1, 1'b0, 1'b1, "t4_after_load2");

        // mode 1->0 freezes line 1, en toggles blank and restore it
        step_a(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 2'd1, 1'b0, 1'b0, "t5_mode_to_direct");
        step_a(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 2'd1, 1'b0, 1'b0, "t5_direct_hold");
        step_a(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000, 2'd1, 1'b0, 1'b0, "t5_en_low");
        step_a(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0010, 2'd1, 1'b0, 1'b0, "t5_en_restore");

        // dwell lowered below the running count: no early advance, count wraps through 255
        step_a(1'b1, 1'b0, 1'b1, 2'd0, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b0, "dw_direct_zero");
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, "dw_enter_scan");
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, "dw_count1");
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd3, 4'b0001, 2'd0, 1'b0, 1'b1, "dw_count2");
        for (int i = 0; i < 256; i++) begin
            s = (i == 255) ? 2'd1 : 2'd0;
            d = 4'b0001 << s;
            step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd1, d, s, 1'b0, 1'b1,
                   $sformatf("dw_lowered[%0d]", i));
        end
        step_a(1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 4'b0010, 2'd1, 1'b0, 1'b1, "dw_next_line");

        // asynchronous reset in the middle of a scan cycle
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back({4'b0000, 2'd0, 1'b0, 1'b0});
        check_a("t1_reset_mid_scan");
        exp_b_q.push_back({8'hFF, 3'd0, 1'b0, 1'b0});
        check_b("t1_reset_b");
        bus_a.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // active-low, 3-bit select
        step_b(1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 8'b1101_1111, 3'd5, 1'b0, 1'b0, "t6_load5");
        step_b(1'b1, 1'b0, 1'b1, 3'd7, 8'd0, 8'b0111_1111, 3'd7, 1'b0, 1'b0, "t6_load7");
        step_b(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'hFF,       3'd7, 1'b0, 1'b0, "t6_en_low");
        step_b(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'b0111_1111, 3'd7, 1'b0, 1'b1, "t6_scan_enter");
        step_b(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'b1111_1110, 3'd0, 1'b1, 1'b1, "t6_scan_wrap");
        step_b(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 8'b1111_1101, 3'd1, 1'b0, 1'b1, "t6_scan_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
